// File: rtl/memlog_reader.sv
// -----------------------------------------------------------------------------
// memlog_reader
//   Read-out engine for the capture log RAM. It takes a start address and a
//   word count, issues reads on the RAM port, absorbs the RAM read latency in
//   a small credit-controlled skid FIFO and streams the words out on a
//   valid/ready source interface. It sustains one word per cycle while the
//   sink holds ready high.
//
//   Optional feature macro: MEMLOG_READER_CKSUM_EN
//     When defined, an XOR checksum of all streamed words is sent as one extra
//     tail beat after the data (also for a zero-length dump).
//
// Ports
//   clka          clock shared with the log RAM
//   rsta_n        asynchronous active-low reset
//   start_i       single-cycle dump request (sampled only in IDLE)
//   start_addr_i  first address to read
//   num_words_i   words to read, 0..RAM_DEPTH
//   ram_addr_o    RAM address
//   ram_en_o      RAM enable, high only on read-issue cycles
//   ram_we_o      RAM write enable, tied low
//   ram_regce_o   RAM output register enable, high outside IDLE
//   ram_dout_i    RAM read data
//   m_data_o      stream data (FIFO head)
//   m_valid_o     stream valid
//   m_ready_i     stream ready
//   busy_o        dump in progress
//   done_o        one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module memlog_reader #(
    parameter int RAM_WIDTH    = 18,
    parameter int RAM_DEPTH    = 1024,
    parameter int ADDR_W       = 10,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    input  logic                 start_i,
    input  logic [ADDR_W-1:0]    start_addr_i,
    input  logic [ADDR_W:0]      num_words_i,
    output logic [ADDR_W-1:0]    ram_addr_o,
    output logic                 ram_en_o,
    output logic                 ram_we_o,
    output logic                 ram_regce_o,
    input  logic [RAM_WIDTH-1:0] ram_dout_i,
    output logic [RAM_WIDTH-1:0] m_data_o,
    output logic                 m_valid_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CR_W  = CNT_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
`ifdef MEMLOG_READER_CKSUM_EN
        , S_TAIL
`endif
    } state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [ADDR_W:0]        remaining_q;
    logic [READ_LATENCY-1:0] pipe_q;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic [CNT_W-1:0]       fifo_count_q, fifo_count_d;
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [RAM_WIDTH-1:0]   fifo_mem_q [FIFO_DEPTH];
`ifdef MEMLOG_READER_CKSUM_EN
    logic [RAM_WIDTH-1:0]   cksum_q;
`endif

    logic            issue, ret, push, pop, fifo_valid;
    logic [CR_W-1:0] credit_used;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credits cover both words already in the FIFO and words still in the
    // RAM pipeline, so a returning word always finds a free slot.
    assign credit_used = CR_W'(fifo_count_q) + CR_W'(inflight_q);
    assign issue = (state_q == S_RUN) && (remaining_q != '0)
                   && (credit_used < CR_W'(FIFO_DEPTH));
    assign ret        = pipe_q[READ_LATENCY-1];
    assign push       = ret;
    assign fifo_valid = (fifo_count_q != '0);
    assign pop        = fifo_valid && m_ready_i;

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !ret) begin
            inflight_d = inflight_q + CNT_W'(1);
        end else if (!issue && ret) begin
            inflight_d = inflight_q - CNT_W'(1);
        end
        fifo_count_d = fifo_count_q;
        if (push && !pop) begin
            fifo_count_d = fifo_count_q + CNT_W'(1);
        end else if (!push && pop) begin
            fifo_count_d = fifo_count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            pipe_q       <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
`ifdef MEMLOG_READER_CKSUM_EN
            cksum_q      <= '0;
`endif
        end else begin
            pipe_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            if (push) begin
                fifo_mem_q[wr_ptr_q] <= ram_dout_i;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
`ifdef MEMLOG_READER_CKSUM_EN
                cksum_q  <= cksum_q ^ fifo_mem_q[rd_ptr_q];
`endif
            end

            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        addr_q      <= start_addr_i;
                        remaining_q <= num_words_i;
`ifdef MEMLOG_READER_CKSUM_EN
                        cksum_q     <= '0;
                        state_q     <= (num_words_i == '0) ? S_TAIL : S_RUN;
`else
                        state_q     <= (num_words_i == '0) ? S_DONE : S_RUN;
`endif
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr_q      <= (addr_q == ADDR_W'(RAM_DEPTH - 1)) ? '0
                                       : addr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - (ADDR_W+1)'(1);
                        if (remaining_q == (ADDR_W+1)'(1)) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Look at next-cycle occupancy so DONE follows the last
                    // accepted beat directly.
                    if ((inflight_d == '0) && (fifo_count_d == '0)) begin
`ifdef MEMLOG_READER_CKSUM_EN
                        state_q <= S_TAIL;
`else
                        state_q <= S_DONE;
`endif
                    end
                end
`ifdef MEMLOG_READER_CKSUM_EN
                S_TAIL: begin
                    if (m_ready_i) begin
                        state_q <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        m_valid_o = fifo_valid;
        m_data_o  = fifo_valid ? fifo_mem_q[rd_ptr_q] : '0;
`ifdef MEMLOG_READER_CKSUM_EN
        if (state_q == S_TAIL) begin
            m_valid_o = 1'b1;
            m_data_o  = cksum_q;
        end
`endif
    end

    assign ram_addr_o  = addr_q;
    assign ram_en_o    = issue;
    assign ram_we_o    = 1'b0;
    assign ram_regce_o = (state_q != S_IDLE);
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_memlog_reader.sv
// -----------------------------------------------------------------------------
// tb_memlog_reader
//   Scoreboard bench for memlog_reader: directed dumps push expected RAM
//   addresses and stream words into queues; a negedge monitor pops and
//   compares on every ram_en_o and every accepted beat.
// -----------------------------------------------------------------------------
module tb_memlog_reader;

    localparam int RW  = 18;
    localparam int RD  = 1024;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int FD  = 4;
`ifdef MEMLOG_READER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic          clka = 1'b0;
    logic          rsta_n = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] start_addr_i = '0;
    logic [AW:0]   num_words_i = '0;
    logic [AW-1:0] ram_addr_o;
    logic          ram_en_o, ram_we_o, ram_regce_o;
    logic [RW-1:0] ram_dout_i;
    logic [RW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i = 1'b1;
    logic          busy_o, done_o;

    memlog_reader #(
        .RAM_WIDTH(RW), .RAM_DEPTH(RD), .ADDR_W(AW),
        .READ_LATENCY(LAT), .FIFO_DEPTH(FD)
    ) dut (
        .clka(clka), .rsta_n(rsta_n), .start_i(start_i),
        .start_addr_i(start_addr_i), .num_words_i(num_words_i),
        .ram_addr_o(ram_addr_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_regce_o(ram_regce_o), .ram_dout_i(ram_dout_i),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clka = ~clka;

    // Log RAM model: registered read plus optional output register.
    logic [RW-1:0] ram [RD];
    logic [RW-1:0] ram_q1 = '0, ram_q2 = '0;
    always @(posedge clka) begin
        if (ram_en_o)    ram_q1 <= ram[ram_addr_o];
        if (ram_regce_o) ram_q2 <= ram_q1;
    end
    assign ram_dout_i = (LAT == 2) ? ram_q2 : ram_q1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    logic [RW-1:0] exp_data_q[$];
    int            exp_addr_q[$];
    int  occ = 0, pops = 0, last_pop_cyc = -1, first_en_cyc = -1, first_val_cyc = -1;
    bit  stall_prev = 1'b0, bp_en = 1'b0;
    logic [RW-1:0] held_data = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] exp_word(input int a);
        case (a)
            100: return 18'h3;
            101: return 18'h5;
            102: return 18'h6;
            200: return 18'h1;
            201: return 18'h2;
            default: return RW'(a + 'h100);
        endcase
    endfunction

    // Sink ready: random toggling during backpressure dumps, else held high.
    initial forever begin
        @(posedge clka); #1;
        m_ready_i = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor / scoreboard.
    always @(negedge clka) begin
        if (!rsta_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 32'(m_valid_o), 32'd1);
                chk("hold_data", 32'(m_data_o), 32'(held_data));
            end
            if (ram_en_o) begin
                chk("ram_we", 32'(ram_we_o), 32'd0);
                chk("credit", 32'(occ < FD), 32'd1);
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: addr 0x%0h, none required", ram_addr_o);
                end else begin
                    chk("ram_addr", 32'(ram_addr_o), 32'(exp_addr_q.pop_front()));
                end
                if (first_en_cyc < 0) first_en_cyc = cyc;
                occ++;
            end
            if (m_valid_o && first_val_cyc < 0) first_val_cyc = cyc;
            if (m_valid_o && m_ready_i) begin
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: data 0x%0h, none required", m_data_o);
                end else begin
                    chk("beat_data", 32'(m_data_o), 32'(exp_data_q.pop_front()));
                end
                pops++;
                last_pop_cyc = cyc;
                if (occ > 0) occ--;
            end
            stall_prev = m_valid_o && !m_ready_i;
            held_data  = m_data_o;
        end
    end

    task automatic prep(input int sa, input int n, input int tail);
        logic [RW-1:0] x;
        x = '0;
        for (int k = 0; k < n; k++) begin
            int a;
            a = (sa + k) % RD;
            exp_addr_q.push_back(a);
            exp_data_q.push_back(exp_word(a));
            x ^= exp_word(a);
        end
        if (CK) exp_data_q.push_back((tail >= 0) ? RW'(tail) : x);
        occ = 0; pops = 0; last_pop_cyc = -1; first_en_cyc = -1; first_val_cyc = -1;
        @(posedge clka); #1;
        start_i = 1'b1; start_addr_i = AW'(sa); num_words_i = (AW+1)'(n);
        @(posedge clka); #1;
        start_i = 1'b0;
    endtask

    task automatic run_dump(input int sa, input int n, input int tail,
                            input bit chk_lat, input bit bp);
        bit seen;
        seen = 1'b0;
        bp_en = bp;
        prep(sa, n, tail);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clka); #1;
            if (done_o) begin seen = 1'b1; break; end
        end
        bp_en = 1'b0;
        if (!seen) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done_o within 2000 cycles, required a pulse");
        end else begin
            chk("busy_in_done", 32'(busy_o), 32'd1);
            chk("beat_count", 32'(pops), 32'(n + (CK ? 1 : 0)));
            chk("data_q_empty", 32'(exp_data_q.size()), 32'd0);
            chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
            if (pops > 0) chk("done_after_last", 32'(cyc - last_pop_cyc), 32'd1);
            if (chk_lat) chk("first_valid_lat", 32'(first_val_cyc - first_en_cyc), 32'd3);
            @(negedge clka); #1;
            chk("done_pulse", 32'(done_o), 32'd0);
            chk("busy_idle", 32'(busy_o), 32'd0);
        end
        $display("dump start=%0d words=%0d beats=%0d", sa, n, pops);
        exp_data_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_ram_addr"}, 32'(ram_addr_o), 32'd0);
        chk({tag, "_ram_en"}, 32'(ram_en_o), 32'd0);
        chk({tag, "_ram_regce"}, 32'(ram_regce_o), 32'd0);
        chk({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
        chk({tag, "_m_data"}, 32'(m_data_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
        chk({tag, "_done"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        bit got3;
        for (int i = 0; i < RD; i++) ram[i] = exp_word(i);

        repeat (3) @(posedge clka);
        #1;
        chk_outputs_zero("reset");
        rsta_n = 1'b1;
        repeat (2) @(posedge clka);

        run_dump(5, 8, -1, 1'b1, 1'b0);       // basic, latency and back-to-back
        run_dump(1022, 4, -1, 1'b0, 1'b0);    // address wrap
        run_dump(300, 16, -1, 1'b0, 1'b1);    // random backpressure
        run_dump(50, 0, 0, 1'b0, 1'b0);       // zero-length dump
        run_dump(100, 3, 0, 1'b0, 1'b0);      // 3^5^6 = 0
        run_dump(200, 2, 3, 1'b0, 1'b0);      // 1^2 = 3

        // Reset in the middle of a dump, after three beats.
        prep(400, 8, -1);
        got3 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clka); #2;
            if (pops >= 3) begin got3 = 1'b1; break; end
        end
        chk("mid_dump_3_beats", 32'(got3), 32'd1);
        chk("mid_dump_busy", 32'(busy_o), 32'd1);
        rsta_n = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        exp_data_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clka);
        #2;
        chk_outputs_zero("held_reset");
        rsta_n = 1'b1;
        repeat (3) @(posedge clka);
        #1;
        chk("post_reset_idle", 32'(busy_o), 32'd0);
        run_dump(500, 2, -1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
